// File: rtl/mpmr_fifo.sv
// Multi-port-write / multi-port-read circular FIFO used as the width-converting
// elastic buffer between the packing stage and the consumer datapath.
module mpmr_fifo #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAR_WRITE = 2,
    parameter int unsigned PAR_READ  = 4,
    parameter int unsigned AF_LEVEL  = 6,
    parameter int unsigned AE_LEVEL  = 1,
    localparam int unsigned CW       = $clog2(DEPTH + 1),
    localparam int unsigned WCW      = $clog2(PAR_WRITE + 1),
    localparam int unsigned RCW      = $clog2(PAR_READ + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear,
    input  logic                      wen,
    input  logic [WCW-1:0]            wcnt,
    input  logic [WIDTH*PAR_WRITE-1:0] din,
    input  logic                      ren,
    input  logic [RCW-1:0]            rcnt,
    output logic [WIDTH*PAR_READ-1:0] dout,
    output logic                      dvalid,
    output logic [CW-1:0]             count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      wr_ok,
    output logic                      rd_ok,
    output logic                      ovf,
    output logic                      udf
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = CW + 1;

    // Reject nonsensical configurations at elaboration time.
    if (WIDTH < 1 || PAR_WRITE < 1 || PAR_READ < 1 ||
        DEPTH < PAR_WRITE || DEPTH < PAR_READ) begin : g_bad_params
        $error("mpmr_fifo: DEPTH must be >= PAR_WRITE and PAR_READ, all parameters >= 1");
    end

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [WIDTH-1:0]          mem_d [DEPTH];
    logic [CW-1:0]             wptr_q, wptr_d;
    logic [CW-1:0]             rptr_q, rptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [WIDTH*PAR_READ-1:0] dout_q, dout_d;
    logic                      dvalid_q, dvalid_d;
    logic                      ovf_q, ovf_d;
    logic                      udf_q, udf_d;
    logic [CW-1:0]             free_c;
    logic                      wacc_c, racc_c;

    // Pointer wrap by compare-and-subtract; the sum is always below 2*DEPTH.
    function automatic logic [CW-1:0] wrap_idx(input logic [PW-1:0] s);
        return (s >= PW'(DEPTH)) ? CW'(s - PW'(DEPTH)) : CW'(s);
    endfunction

    // Acceptance decode against the pre-edge occupancy.
    always_comb begin
        free_c = CW'(DEPTH) - count_q;
        wr_ok  = PW'(wcnt) <= PW'(free_c);
        rd_ok  = PW'(rcnt) <= PW'(count_q);
        wacc_c = wen && (wcnt != '0) && (32'(wcnt) <= PAR_WRITE) && wr_ok;
        racc_c = ren && (rcnt != '0) && (32'(rcnt) <= PAR_READ) && rd_ok;
    end

    // Next-state for storage, pointers, occupancy, read data and sticky errors.
    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        ovf_d    = ovf_q | (wen & ~wacc_c);
        udf_d    = udf_q | (ren & ~racc_c);
        count_d  = CW'(PW'(count_q)
                       + (wacc_c ? PW'(wcnt) : PW'(0))
                       - (racc_c ? PW'(rcnt) : PW'(0)));
        if (wacc_c) begin
            for (int k = 0; k < PAR_WRITE; k++) begin
                if (32'(k) < 32'(wcnt)) begin
                    mem_d[AW'(wrap_idx(PW'(wptr_q) + PW'(k)))] = din[k*WIDTH +: WIDTH];
                end
            end
            wptr_d = wrap_idx(PW'(wptr_q) + PW'(wcnt));
        end
        if (racc_c) begin
            for (int k = 0; k < PAR_READ; k++) begin
                dout_d[k*WIDTH +: WIDTH] = (32'(k) < 32'(rcnt))
                    ? mem_q[AW'(wrap_idx(PW'(rptr_q) + PW'(k)))]
                    : '0;
            end
            rptr_d   = wrap_idx(PW'(rptr_q) + PW'(rcnt));
            dvalid_d = 1'b1;
        end
    end

    // Control registers; reset and clear flush identically.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents are irrelevant after a flush so it has no reset.
    always_ff @(posedge clk) begin
        if (rstn && !clear) begin
            mem_q <= mem_d;
        end
    end

    assign dout         = dout_q;
    assign dvalid       = dvalid_q;
    assign count        = count_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (32'(count_q) >= AF_LEVEL);
    assign almost_empty = (32'(count_q) <= AE_LEVEL);

endmodule

// File: tb/tb_mpmr_fifo.sv
// Scoreboard bench for mpmr_fifo: a default instance (DEPTH=8) and a DEPTH=6
// instance share stimulus; a queue-based word model predicts both.
module tb_mpmr_fifo;

    typedef logic [15:0] word_t;

    logic        clk = 1'b0;
    logic        rstn, clear, wen, ren;
    logic [1:0]  wcnt;
    logic [2:0]  rcnt;
    logic [31:0] din;

    logic [63:0] dout0, dout1;
    logic        dvalid0, dvalid1;
    logic [3:0]  count0;
    logic [2:0]  count1;
    logic        full0, empty0, af0, ae0, wrok0, rdok0, ovf0, udf0;
    logic        full1, empty1, af1, ae1, wrok1, rdok1, ovf1, udf1;

    always #5 clk = ~clk;

    mpmr_fifo u_dut8 (
        .clk(clk), .rstn(rstn), .clear(clear), .wen(wen), .wcnt(wcnt), .din(din),
        .ren(ren), .rcnt(rcnt), .dout(dout0), .dvalid(dvalid0), .count(count0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .wr_ok(wrok0), .rd_ok(rdok0), .ovf(ovf0), .udf(udf0)
    );

    mpmr_fifo #(.DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut6 (
        .clk(clk), .rstn(rstn), .clear(clear), .wen(wen), .wcnt(wcnt), .din(din),
        .ren(ren), .rcnt(rcnt), .dout(dout1), .dvalid(dvalid1), .count(count1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .wr_ok(wrok1), .rd_ok(rdok1), .ovf(ovf1), .udf(udf1)
    );

    // Reference model state: word queues, expected-read scoreboards, flags.
    word_t       mq0[$], mq1[$];
    logic [63:0] sb0[$], sb1[$];
    bit          e_ovf[2], e_udf[2], e_dv[2];
    logic [63:0] e_dout[2];
    int          n_chk = 0, n_pass = 0;
    bit          mon_en = 1'b0, initd = 1'b0;
    word_t       wseq = 16'hA000;

    function automatic int dep(int i);  return (i == 0) ? 8 : 6; endfunction
    function automatic int afl(int i);  return (i == 0) ? 6 : 4; endfunction
    function automatic int msize(int i); return (i == 0) ? mq0.size() : mq1.size(); endfunction
    function automatic int sbsize(int i); return (i == 0) ? sb0.size() : sb1.size(); endfunction
    function automatic word_t mpop(int i);
        if (i == 0) return mq0.pop_front();
        return mq1.pop_front();
    endfunction
    function automatic void mpush(int i, word_t w);
        if (i == 0) mq0.push_back(w); else mq1.push_back(w);
    endfunction
    function automatic void mclr(int i);
        if (i == 0) mq0.delete(); else mq1.delete();
    endfunction
    function automatic logic [63:0] sbpop(int i);
        if (i == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction
    function automatic void sbpush(int i, logic [63:0] v);
        if (i == 0) sb0.push_back(v); else sb1.push_back(v);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Predict the effect of the coming clock edge for instance i.
    task automatic model_step(int i, bit rst, bit clr, bit we, int wc, logic [31:0] d,
                              bit re, int rc);
        int          cnt;
        bit          wa, ra;
        logic [63:0] o;
        if (rst || clr) begin
            mclr(i);
            e_ovf[i] = 0; e_udf[i] = 0; e_dv[i] = 0; e_dout[i] = '0;
            return;
        end
        cnt = msize(i);
        wa  = we && wc >= 1 && wc <= 2 && wc <= dep(i) - cnt;
        ra  = re && rc >= 1 && rc <= 4 && rc <= cnt;
        if (we && !wa) e_ovf[i] = 1;
        if (re && !ra) e_udf[i] = 1;
        e_dv[i] = ra;
        if (ra) begin
            o = '0;
            for (int k = 0; k < rc; k++) o[k*16 +: 16] = mpop(i);
            sbpush(i, o);
            e_dout[i] = o;
        end
        if (wa) begin
            for (int k = 0; k < wc; k++) mpush(i, d[k*16 +: 16]);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and update the model.
    task automatic cyc(bit rst, bit clr, bit we, int wc, bit re, int rc);
        logic [31:0] d;
        @(negedge clk);
        d = {wseq + 16'd1, wseq};
        if (we) wseq = wseq + 16'd2;
        rstn = !rst; clear = clr; wen = we; wcnt = 2'(wc); din = d; ren = re; rcnt = 3'(rc);
        #1;
        if (initd) begin
            chk("wr_ok[0]", 64'(wrok0), 64'(wc <= dep(0) - msize(0)));
            chk("rd_ok[0]", 64'(rdok0), 64'(rc <= msize(0)));
            chk("wr_ok[1]", 64'(wrok1), 64'(wc <= dep(1) - msize(1)));
            chk("rd_ok[1]", 64'(rdok1), 64'(rc <= msize(1)));
        end
        model_step(0, rst, clr, we, wc, d, re, rc);
        model_step(1, rst, clr, we, wc, d, re, rc);
        initd  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic mon(int i, logic [63:0] dout, bit dv, int cnt, bit fu, bit em,
                       bit af, bit ae, bit ov, bit ud);
        int n;
        n = msize(i);
        chk($sformatf("count[%0d]", i), 64'(cnt), 64'(n));
        chk($sformatf("full[%0d]", i), 64'(fu), 64'(n == dep(i)));
        chk($sformatf("empty[%0d]", i), 64'(em), 64'(n == 0));
        chk($sformatf("almost_full[%0d]", i), 64'(af), 64'(n >= afl(i)));
        chk($sformatf("almost_empty[%0d]", i), 64'(ae), 64'(n <= 1));
        chk($sformatf("ovf[%0d]", i), 64'(ov), 64'(e_ovf[i]));
        chk($sformatf("udf[%0d]", i), 64'(ud), 64'(e_udf[i]));
        chk($sformatf("dvalid[%0d]", i), 64'(dv), 64'(e_dv[i]));
        if (dv) begin
            if (sbsize(i) == 0) begin
                n_chk++;
                $display("FAIL dout_sb[%0d]: got unexpected dvalid with data %0h", i, dout);
            end else begin
                chk($sformatf("dout_sb[%0d]", i), dout, sbpop(i));
            end
        end else begin
            chk($sformatf("dout_hold[%0d]", i), dout, e_dout[i]);
        end
    endtask

    // Monitor: compare registered outputs shortly after each active edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            mon(0, dout0, dvalid0, int'(count0), full0, empty0, af0, ae0, ovf0, udf0);
            mon(1, dout1, dvalid1, int'(count1), full1, empty1, af1, ae1, ovf1, udf1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; clear = 1'b0; wen = 1'b0; ren = 1'b0;
        wcnt = '0; rcnt = '0; din = '0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Fill with pairs until full.
        repeat (4) cyc(0, 0, 1, 2, 0, 0);
        @(posedge clk); #2;
        chk("t1_count", 64'(count0), 64'd8);
        chk("t1_full", 64'(full0), 64'd1);
        chk("t1_af", 64'(af0), 64'd1);
        chk("t1_ovf", 64'(ovf0), 64'd0);

        // Write into a full FIFO, then a 4-word read.
        cyc(0, 0, 1, 1, 0, 0);
        @(posedge clk); #2;
        chk("t2_ovf", 64'(ovf0), 64'd1);
        chk("t2_count", 64'(count0), 64'd8);
        cyc(0, 0, 0, 0, 1, 4);
        @(posedge clk); #2;
        chk("t2_dvalid", 64'(dvalid0), 64'd1);
        chk("t2_dout", dout0, 64'hA003_A002_A001_A000);

        // Over-read at count 3, then an exact 3-word read.
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 4);
        @(posedge clk); #2;
        chk("t3_udf", 64'(udf0), 64'd1);
        chk("t3_dvalid", 64'(dvalid0), 64'd0);
        chk("t3_count", 64'(count0), 64'd3);
        cyc(0, 0, 0, 0, 1, 3);
        @(posedge clk); #2;
        chk("t3_dout", dout0, 64'h0000_A007_A006_A005);
        chk("t3_count0", 64'(count0), 64'd0);

        // Steady streaming; the DEPTH=6 pointers wrap repeatedly.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 2, 0, 0);
        repeat (20) cyc(0, 0, 1, 2, 1, 2);
        @(posedge clk); #2;
        chk("t4_count6", 64'(count1), 64'd2);
        chk("t4_ovf6", 64'(ovf1), 64'd0);
        chk("t4_udf6", 64'(udf1), 64'd0);

        // Simultaneous read and write at count 7 use the pre-edge count.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 2, 0, 0);
        cyc(0, 0, 1, 2, 0, 0);
        cyc(0, 0, 1, 2, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 2, 1, 1);
        @(posedge clk); #2;
        chk("t5_ovf", 64'(ovf0), 64'd1);
        chk("t5_count", 64'(count0), 64'd6);
        chk("t5_dvalid", 64'(dvalid0), 64'd1);

        // Clear wins over concurrent read and write.
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 1, 2, 1, 2);
        @(posedge clk); #2;
        chk("t6_count", 64'(count0), 64'd0);
        chk("t6_empty", 64'(empty0), 64'd1);
        chk("t6_ovf", 64'(ovf0), 64'd0);
        chk("t6_udf", 64'(udf0), 64'd0);
        chk("t6_dvalid", 64'(dvalid0), 64'd0);

        // Randomized traffic including illegal counts, clears and resets.
        repeat (400) begin
            int r;
            r = $urandom_range(0, 99);
            cyc(r == 0, r == 1 || r == 2, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 7));
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("sb_drained0", 64'(sbsize(0)), 64'd0);
        chk("sb_drained1", 64'(sbsize(1)), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
